// File: rtl/runway_scheduler.sv
// runway_scheduler: two-runway grant scheduler with landing/takeoff FIFOs and a single emergency slot.
// Define LANDING_PRIORITY_EN to serve the landing queue strictly before the takeoff queue.
module runway_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_id,
    input  logic       req_land,
    input  logic       emerg_valid,
    input  logic [3:0] emerg_id,
    input  logic       rel_valid,
    input  logic       rel_runway,
    input  logic [1:0] runway_override,
    input  logic       emergency_override,
    output logic       grant_valid,
    output logic [3:0] grant_id,
    output logic       grant_runway,
    output logic       grant_emerg,
    output logic [1:0] runway_active,
    output logic       emergency,
    output logic       land_full,
    output logic       take_full,
    output logic       req_drop
);

    logic [3:0] r_lq_mem [4];
    logic [3:0] r_tq_mem [4];
    logic [1:0] r_lq_rd, r_lq_wr, r_tq_rd, r_tq_wr;
    logic [2:0] r_lq_cnt, r_tq_cnt;
    logic       r_em_vld;
    logic [3:0] r_em_id;
    logic       r_last_land;
    logic [1:0] r_active;

    logic [1:0] w_free;
    logic       w_any_free;
    logic       w_rwy;
    logic       w_lq_ne, w_tq_ne;
    logic       w_grant_em;
    logic       w_q_ok;
    logic       w_pick_land;
    logic       w_pop_lq, w_pop_tq;
    logic       w_push_lq, w_push_tq;
    logic       w_req_rej;
    logic       w_em_load, w_em_rej;
    logic       w_gnt;
    logic [3:0] w_gnt_id;
    logic [1:0] w_rel_clr, w_set;

    // All decisions use start-of-cycle registered state only.
    assign w_free     = ~r_active & ~runway_override;
    assign w_any_free = |w_free;
    assign w_rwy      = ~w_free[0];
    assign w_lq_ne    = (r_lq_cnt != 3'd0);
    assign w_tq_ne    = (r_tq_cnt != 3'd0);

    assign w_grant_em = r_em_vld & w_any_free;
    assign w_q_ok     = ~r_em_vld & ~emergency_override & w_any_free;

`ifdef LANDING_PRIORITY_EN
    assign w_pick_land = w_lq_ne;
`else
    assign w_pick_land = w_lq_ne & (~w_tq_ne | ~r_last_land);
`endif

    assign w_pop_lq  = w_q_ok & w_pick_land;
    assign w_pop_tq  = w_q_ok & ~w_pick_land & w_tq_ne;
    assign w_push_lq = req_valid &  req_land & (r_lq_cnt != 3'd4);
    assign w_push_tq = req_valid & ~req_land & (r_tq_cnt != 3'd4);
    assign w_req_rej = req_valid & (req_land ? (r_lq_cnt == 3'd4) : (r_tq_cnt == 3'd4));
    assign w_em_load = emerg_valid & ~r_em_vld;
    assign w_em_rej  = emerg_valid &  r_em_vld;

    assign w_gnt     = w_grant_em | w_pop_lq | w_pop_tq;
    assign w_gnt_id  = w_grant_em ? r_em_id :
                       w_pop_lq   ? r_lq_mem[r_lq_rd] : r_tq_mem[r_tq_rd];
    assign w_rel_clr = rel_valid ? (2'b01 << rel_runway) : 2'b00;
    assign w_set     = w_gnt ? (2'b01 << w_rwy) : 2'b00;

    // Payload storage carries no reset; occupancy lives in the pointers and counts.
    always_ff @(posedge clock) begin
        if (w_push_lq) r_lq_mem[r_lq_wr] <= req_id;
        if (w_push_tq) r_tq_mem[r_tq_wr] <= req_id;
        if (w_em_load) r_em_id <= emerg_id;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lq_rd      <= '0;
            r_lq_wr      <= '0;
            r_lq_cnt     <= '0;
            r_tq_rd      <= '0;
            r_tq_wr      <= '0;
            r_tq_cnt     <= '0;
            r_em_vld     <= 1'b0;
            r_last_land  <= 1'b0;
            r_active     <= '0;
            emergency    <= 1'b0;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            grant_runway <= 1'b0;
            grant_emerg  <= 1'b0;
            req_drop     <= 1'b0;
        end else begin
            r_lq_wr  <= r_lq_wr + 2'(w_push_lq);
            r_lq_rd  <= r_lq_rd + 2'(w_pop_lq);
            r_lq_cnt <= r_lq_cnt + 3'(w_push_lq) - 3'(w_pop_lq);
            r_tq_wr  <= r_tq_wr + 2'(w_push_tq);
            r_tq_rd  <= r_tq_rd + 2'(w_pop_tq);
            r_tq_cnt <= r_tq_cnt + 3'(w_push_tq) - 3'(w_pop_tq);

            if (w_grant_em)     r_em_vld <= 1'b0;
            else if (w_em_load) r_em_vld <= 1'b1;
            // Lags the slot by one cycle on release so it stays up through the grant pulse.
            emergency <= r_em_vld | w_em_load;

            if (w_pop_lq | w_pop_tq) r_last_land <= w_pop_lq;

            r_active     <= (r_active & ~w_rel_clr) | w_set;
            grant_valid  <= w_gnt;
            grant_id     <= w_gnt ? w_gnt_id : 4'd0;
            grant_runway <= w_gnt & w_rwy;
            grant_emerg  <= w_grant_em;
            req_drop     <= w_req_rej | w_em_rej;
        end
    end

    assign runway_active = r_active;
    assign land_full     = (r_lq_cnt == 3'd4);
    assign take_full     = (r_tq_cnt == 3'd4);

endmodule

// File: tb/tb_runway_scheduler.sv
// Testbench for runway_scheduler: scenario tasks with inline checks plus a grant scoreboard.
module tb_runway_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_id;
    logic       req_land;
    logic       emerg_valid;
    logic [3:0] emerg_id;
    logic       rel_valid;
    logic       rel_runway;
    logic [1:0] runway_override;
    logic       emergency_override;
    logic       grant_valid;
    logic [3:0] grant_id;
    logic       grant_runway;
    logic       grant_emerg;
    logic [1:0] runway_active;
    logic       emergency;
    logic       land_full;
    logic       take_full;
    logic       req_drop;

    runway_scheduler dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_id             (req_id),
        .req_land           (req_land),
        .emerg_valid        (emerg_valid),
        .emerg_id           (emerg_id),
        .rel_valid          (rel_valid),
        .rel_runway         (rel_runway),
        .runway_override    (runway_override),
        .emergency_override (emergency_override),
        .grant_valid        (grant_valid),
        .grant_id           (grant_id),
        .grant_runway       (grant_runway),
        .grant_emerg        (grant_emerg),
        .runway_active      (runway_active),
        .emergency          (emergency),
        .land_full          (land_full),
        .take_full          (take_full),
        .req_drop           (req_drop)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] id;
        logic       rwy;
        logic       em;
    } gnt_t;

    gnt_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Every observed grant must match the oldest expected one.
    always @(negedge clock) begin
        if (grant_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d rwy=%0d em=%0d, required no grant",
                         grant_id, grant_runway, grant_emerg);
            end else begin
                gnt_t e;
                e = exp_q.pop_front();
                if ({grant_id, grant_runway, grant_emerg} !== e) begin
                    n_fail++;
                    $display("FAIL sb_grant: got id=%0d rwy=%0d em=%0d, required id=%0d rwy=%0d em=%0d",
                             grant_id, grant_runway, grant_emerg, e.id, e.rwy, e.em);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic idle();
        req_valid = 0; req_land = 0; req_id = 0;
        emerg_valid = 0; emerg_id = 0;
        rel_valid = 0; rel_runway = 0;
    endtask

    task automatic expect_gnt(input logic [3:0] id, input logic rwy, input logic em);
        gnt_t g;
        g.id = id; g.rwy = rwy; g.em = em;
        exp_q.push_back(g);
    endtask

    task automatic req(input logic land, input logic [3:0] id);
        req_valid = 1; req_land = land; req_id = id;
    endtask

    task automatic do_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d grants outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        idle(); runway_override = 0; emergency_override = 0;
        reset = 1; cyc(2); reset = 0;
    endtask

    task automatic test_reset();
        idle(); runway_override = 0; emergency_override = 0;
        reset = 1; cyc(2);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway, grant_emerg, runway_active, emergency,
             land_full, take_full, req_drop} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gv=%b id=%0d act=%b em=%b lf=%b tf=%b drop=%b, required all 0",
                     grant_valid, grant_id, runway_active, emergency, land_full, take_full, req_drop);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        req(1, 3); expect_gnt(3, 0, 0); cyc(1);
        req(0, 5); expect_gnt(5, 1, 0); cyc(1);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway} !== {1'b1, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_first: got gv=%b id=%0d rwy=%0d, required gv=1 id=3 rwy=0",
                     grant_valid, grant_id, grant_runway);
        end
        idle(); cyc(1);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway, runway_active} !== {1'b1, 4'd5, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL basic_second: got gv=%b id=%0d rwy=%0d act=%b, required gv=1 id=5 rwy=1 act=11",
                     grant_valid, grant_id, grant_runway, runway_active);
        end
        cyc(1);
        n_tests++;
        if (grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: got gv=%b, required 0", grant_valid);
        end
    endtask

    task automatic test_full();
        runway_override = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            req(1, 4'(i)); cyc(1);
            n_tests++;
            if ({land_full, req_drop} !== {(i == 4), 1'b0}) begin
                n_fail++;
                $display("FAIL full_fill%0d: got lf=%b drop=%b, required lf=%0d drop=0",
                         i, land_full, req_drop, (i == 4));
            end
        end
        req(1, 5); cyc(1);
        n_tests++;
        if ({land_full, req_drop} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_drop: got lf=%b drop=%b, required lf=1 drop=1", land_full, req_drop);
        end
        idle(); cyc(1);
        n_tests++;
        if (req_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drop_pulse: got drop=%b, required 0", req_drop);
        end
        runway_override = 2'b00;
        req(1, 6); expect_gnt(1, 0, 0); expect_gnt(2, 1, 0); cyc(1);
        n_tests++;
        if ({req_drop, grant_valid, grant_id, land_full} !== {1'b1, 1'b1, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_pop_push: got drop=%b gv=%b id=%0d lf=%b, required drop=1 gv=1 id=1 lf=0",
                     req_drop, grant_valid, grant_id, land_full);
        end
        idle(); cyc(2);
        expect_gnt(3, 0, 0);
        rel_valid = 1; rel_runway = 0; cyc(1); idle(); cyc(2);
        expect_gnt(4, 1, 0);
        rel_valid = 1; rel_runway = 1; cyc(1); idle(); cyc(2);
        rel_valid = 1; rel_runway = 0; cyc(1); idle(); cyc(3);
    endtask

    task automatic test_emergency();
        req(1, 1); expect_gnt(1, 0, 0); cyc(1);
        req(1, 4); expect_gnt(4, 1, 0); cyc(1);
        req(1, 2); cyc(1);
        idle(); emerg_valid = 1; emerg_id = 9; expect_gnt(9, 1, 1); cyc(1);
        n_tests++;
        if ({emergency, runway_active} !== {1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL emerg_pending: got em=%b act=%b, required em=1 act=11", emergency, runway_active);
        end
        emerg_id = 12; rel_valid = 1; rel_runway = 1; cyc(1);
        n_tests++;
        if ({req_drop, emergency, grant_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL emerg_slot_busy: got drop=%b em=%b gv=%b, required drop=1 em=1 gv=0",
                     req_drop, emergency, grant_valid);
        end
        idle(); cyc(1);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway, grant_emerg, emergency} !== {1'b1, 4'd9, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL emerg_grant: got gv=%b id=%0d rwy=%0d ge=%b em=%b, required gv=1 id=9 rwy=1 ge=1 em=1",
                     grant_valid, grant_id, grant_runway, grant_emerg, emergency);
        end
        cyc(1);
        n_tests++;
        if ({emergency, grant_valid, runway_active} !== {1'b0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL emerg_fall: got em=%b gv=%b act=%b, required em=0 gv=0 act=11",
                     emergency, grant_valid, runway_active);
        end
        cyc(2);
        expect_gnt(2, 0, 0);
        rel_valid = 1; rel_runway = 0; cyc(1); idle(); cyc(3);
    endtask

    task automatic test_override();
        emergency_override = 1;
        req(0, 7); cyc(1); idle(); cyc(3);
        n_tests++;
        if (grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL override_hold: got gv=%b, required 0", grant_valid);
        end
        emergency_override = 0; expect_gnt(7, 0, 0); cyc(1);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway} !== {1'b1, 4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL override_release: got gv=%b id=%0d rwy=%0d, required gv=1 id=7 rwy=0",
                     grant_valid, grant_id, grant_runway);
        end
        cyc(2);
    endtask

    task automatic test_order();
        logic [3:0] ord [3];
        ord[0] = 1;
`ifdef LANDING_PRIORITY_EN
        ord[1] = 2; ord[2] = 8;
`else
        ord[1] = 8; ord[2] = 2;
`endif
        runway_override = 2'b11;
        req(1, 1); cyc(1);
        req(1, 2); cyc(1);
        req(0, 8); cyc(1);
        idle();
        for (int k = 0; k < 3; k++) expect_gnt(ord[k], 0, 0);
        runway_override = 2'b10; cyc(1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                rel_valid = 1; rel_runway = 0; cyc(1); idle(); cyc(1);
            end
            n_tests++;
            if ({grant_valid, grant_id} !== {1'b1, ord[k]}) begin
                n_fail++;
                $display("FAIL order_%0d: got gv=%b id=%0d, required gv=1 id=%0d",
                         k, grant_valid, grant_id, ord[k]);
            end
        end
        cyc(2);
    endtask

    task automatic test_midreset();
        runway_override = 2'b10;
        req(1, 1); expect_gnt(1, 0, 0); cyc(1);
        req(1, 2); cyc(1);
        req(0, 3); cyc(1);
        idle(); cyc(1);
        n_tests++;
        if (runway_active !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_setup: got act=%b, required 01", runway_active);
        end
        reset = 1; req(1, 4); emerg_valid = 1; emerg_id = 5; cyc(1);
        n_tests++;
        if ({grant_valid, grant_id, grant_runway, grant_emerg, runway_active, emergency,
             land_full, take_full, req_drop} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got gv=%b id=%0d act=%b em=%b drop=%b, required all 0",
                     grant_valid, grant_id, runway_active, emergency, req_drop);
        end
        reset = 0; idle(); runway_override = 2'b00; cyc(4);
        n_tests++;
        if ({runway_active, emergency, land_full, take_full} !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_empty: got act=%b em=%b lf=%b tf=%b, required all 0",
                     runway_active, emergency, land_full, take_full);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        do_reset();
        test_full();
        do_reset();
        test_emergency();
        do_reset();
        test_override();
        do_reset();
        test_order();
        do_reset();
        test_midreset();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
